// File: rtl/usb_rx_pkg.sv
// Shared types and default timing constants for the USB receive line-state path.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_K   = 2'b01,
    LS_J   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_t;

  typedef enum logic [1:0] {
    IDLE,
    SE0_RUN,
    BUS_RST
  } eop_state_t;

  localparam int unsigned DEF_MIN_EOP_CLKS = 12;
  localparam int unsigned DEF_MAX_EOP_CLKS = 24;
  localparam int unsigned DEF_RESET_CLKS   = 200;

endpackage

// File: rtl/usb_eop_linestate_if.sv
// Line-side bundle for usb_eop_linestate: raw D+/D- in, classified line state and EOP events out.
interface usb_eop_linestate_if;
  import usb_rx_pkg::*;

  logic        d_plus;
  logic        d_minus;
  line_state_t line_state;
  logic        se0;
  logic        eop;
  logic        eop_err;
  logic        bus_reset;

  modport master (
    output d_plus, d_minus,
    input  line_state, se0, eop, eop_err, bus_reset
  );

  modport slave (
    input  d_plus, d_minus,
    output line_state, se0, eop, eop_err, bus_reset
  );

endinterface

// File: rtl/usb_sync2.sv
// Two-flop synchroniser for one asynchronous line, with a configurable reset level.
module usb_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/usb_eop_linestate.sv
// Synchronised USB line-state classifier with SE0 timing, EOP qualification and bus-reset detection.
// Optional macro USB_EOP_MAXLEN_EN: SE0 runs longer than MAX_EOP_CLKS ending in J report eop_err.
module usb_eop_linestate
  import usb_rx_pkg::*;
#(
  parameter int unsigned MIN_EOP_CLKS = DEF_MIN_EOP_CLKS,
  parameter int unsigned MAX_EOP_CLKS = DEF_MAX_EOP_CLKS,
  parameter int unsigned RESET_CLKS   = DEF_RESET_CLKS
) (
  input logic                  clk,
  input logic                  n_rst,
  usb_eop_linestate_if.slave   bus
);

  // Sized from the larger bound so a misordered configuration cannot truncate a limit.
  localparam int unsigned CNT_MAX = (MAX_EOP_CLKS > RESET_CLKS) ? MAX_EOP_CLKS : RESET_CLKS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_EOP_CLKS);
  localparam logic [CNT_W-1:0] RST_C = CNT_W'(RESET_CLKS);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic             dp_s;
  logic             dm_s;
  line_state_t      ls;
  eop_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             len_ok;
  logic             eop_q;
  logic             eop_err_q;
  logic             bus_reset_q;

  // D+ idles high and D- low, so the synchronisers reset to J.
  usb_sync2 #(.RST_VAL(1'b1)) u_sync_dp (
    .clk   (clk),
    .n_rst (n_rst),
    .d     (bus.d_plus),
    .q     (dp_s)
  );

  usb_sync2 #(.RST_VAL(1'b0)) u_sync_dm (
    .clk   (clk),
    .n_rst (n_rst),
    .d     (bus.d_minus),
    .q     (dm_s)
  );

  assign ls      = line_state_t'({dp_s, dm_s});
  assign cnt_inc = cnt + ONE_C;

`ifdef USB_EOP_MAXLEN_EN
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_EOP_CLKS);
  assign len_ok = (cnt <= MAX_C);
`else
  assign len_ok = 1'b1;
`endif

  // SE0 run tracker; pulses are judged on the first synced non-SE0 cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      eop_q       <= 1'b0;
      eop_err_q   <= 1'b0;
      bus_reset_q <= 1'b0;
    end else begin
      eop_q     <= 1'b0;
      eop_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (ls == LS_SE0) begin
            state <= SE0_RUN;
            cnt   <= ONE_C;
          end
        end
        SE0_RUN: begin
          if (ls == LS_SE0) begin
            cnt <= cnt_inc;
            if (cnt_inc == RST_C) begin
              state       <= BUS_RST;
              bus_reset_q <= 1'b1;
            end
          end else begin
            state <= IDLE;
            if (cnt >= MIN_C) begin
              if ((ls == LS_J) && len_ok) eop_q     <= 1'b1;
              else                        eop_err_q <= 1'b1;
            end
          end
        end
        BUS_RST: begin
          if (ls != LS_SE0) begin
            state       <= IDLE;
            bus_reset_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.line_state = ls;
  assign bus.se0        = (ls == LS_SE0);
  assign bus.eop        = eop_q;
  assign bus.eop_err    = eop_err_q;
  assign bus.bus_reset  = bus_reset_q;

endmodule

// File: tb/tb_usb_eop_linestate.sv
// Randomised bench for usb_eop_linestate against a run-length reference model, plus directed timing checks.
module tb_usb_eop_linestate;
  import usb_rx_pkg::*;

  localparam int unsigned MIN = 12;
  localparam int unsigned MAX = 24;
  localparam int unsigned RST = 200;
  localparam logic [1:0] SE0 = 2'b00, K = 2'b01, J = 2'b10, SE1 = 2'b11;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  usb_eop_linestate_if bus ();

  usb_eop_linestate #(
    .MIN_EOP_CLKS (MIN),
    .MAX_EOP_CLKS (MAX),
    .RESET_CLKS   (RST)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  function automatic bit len_ok(input int r);
`ifdef USB_EOP_MAXLEN_EN
    return r <= int'(MAX);
`else
    return 1'b1;
`endif
  endfunction

  // Reference: the decision point sees the raw line two samples late; judge each finished SE0 run by its length.
  logic [1:0] p1, p2, exp_ls;
  logic       exp_eop, exp_err, exp_brst;
  int         run;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      p1 = J; p2 = J; run = 0;
      exp_eop = 0; exp_err = 0; exp_brst = 0; exp_ls = J;
    end else begin
      exp_eop = 0;
      exp_err = 0;
      if (p2 == SE0) run++;
      else begin
        if (run >= int'(MIN) && run < int'(RST)) begin
          if (p2 == J && len_ok(run)) exp_eop = 1;
          else                        exp_err = 1;
        end
        run = 0;
      end
      exp_brst = (run >= int'(RST));
      exp_ls   = p1;
      p2 = p1;
      p1 = {bus.d_plus, bus.d_minus};
    end
  end

  // Event monitor for directed expectations.
  int eop_cnt, err_cnt, eop_cyc, err_cyc, rise_cyc, fall_cyc, clash_cnt;
  logic prev_brst = 1'b0;

  task automatic clear_mon();
    eop_cnt = 0; err_cnt = 0; eop_cyc = -1; err_cyc = -1;
    rise_cyc = -1; fall_cyc = -1; clash_cnt = 0;
  endtask

  always @(negedge clk) begin
    chk("line_state", 32'(bus.line_state), 32'(exp_ls));
    chk("se0", 32'(bus.se0), 32'(exp_ls == SE0));
    chk("eop", 32'(bus.eop), 32'(exp_eop));
    chk("eop_err", 32'(bus.eop_err), 32'(exp_err));
    chk("bus_reset", 32'(bus.bus_reset), 32'(exp_brst));
    if (bus.eop) begin eop_cnt++; if (eop_cyc < 0) eop_cyc = cyc; end
    if (bus.eop_err) begin err_cnt++; if (err_cyc < 0) err_cyc = cyc; end
    if ((bus.eop && bus.eop_err) || (bus.eop && bus.bus_reset)) clash_cnt++;
    if (bus.bus_reset && !prev_brst && rise_cyc < 0) rise_cyc = cyc;
    if (!bus.bus_reset && prev_brst && fall_cyc < 0) fall_cyc = cyc;
    prev_brst = bus.bus_reset;
  end

  // Holds v on the raw lines for n sampling edges; returns just after the last edge.
  task automatic drive(input logic [1:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      {bus.d_plus, bus.d_minus} = v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic burst(input int n, input logic [1:0] term, output int s0c, output int jc);
    clear_mon();
    s0c = cyc;
    drive(SE0, n);
    jc = cyc;
    drive(term, 6);
    drive(J, 2);
  endtask

  int s0c, jc;
  logic [1:0] sym;

  initial begin
    {bus.d_plus, bus.d_minus} = J;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line_state", 32'(bus.line_state), 32'h2);
    chk("rst_se0", 32'(bus.se0), 32'h0);
    chk("rst_eop", 32'(bus.eop), 32'h0);
    chk("rst_eop_err", 32'(bus.eop_err), 32'h0);
    chk("rst_bus_reset", 32'(bus.bus_reset), 32'h0);
    n_rst = 1'b1;
    drive(J, 5);

    burst(12, J, s0c, jc);
    chk("eop12_count", 32'(eop_cnt), 32'd1);
    chk("eop12_latency", 32'(eop_cyc - jc), 32'd3);
    chk("eop12_err", 32'(err_cnt), 32'd0);
    chk("eop12_brst", 32'(rise_cyc), 32'hFFFF_FFFF);

    burst(11, J, s0c, jc);
    chk("glitch11_eop", 32'(eop_cnt), 32'd0);
    chk("glitch11_err", 32'(err_cnt), 32'd0);
    burst(12, J, s0c, jc);
    chk("after_glitch_eop", 32'(eop_cnt), 32'd1);

    burst(16, K, s0c, jc);
    chk("k16_err_count", 32'(err_cnt), 32'd1);
    chk("k16_err_latency", 32'(err_cyc - jc), 32'd3);
    chk("k16_eop", 32'(eop_cnt), 32'd0);

    burst(14, SE1, s0c, jc);
    chk("se1_14_err", 32'(err_cnt), 32'd1);

    burst(250, J, s0c, jc);
    chk("brst_rise", 32'(rise_cyc - s0c), 32'd202);
    chk("brst_fall", 32'(fall_cyc - jc), 32'd3);
    chk("brst_eop", 32'(eop_cnt), 32'd0);
    chk("brst_err", 32'(err_cnt), 32'd0);

    burst(30, J, s0c, jc);
`ifdef USB_EOP_MAXLEN_EN
    chk("long30_err", 32'(err_cnt), 32'd1);
    chk("long30_eop", 32'(eop_cnt), 32'd0);
`else
    chk("long30_err", 32'(err_cnt), 32'd0);
    chk("long30_eop", 32'(eop_cnt), 32'd1);
`endif
    burst(20, J, s0c, jc);
    chk("mid20_eop", 32'(eop_cnt), 32'd1);

    clear_mon();
    drive(SE1, 3);
    drive(J, 4);
    chk("idle_se1_err", 32'(err_cnt), 32'd0);

    // Reset part-way through an SE0 run must discard the partial count.
    clear_mon();
    drive(SE0, 8);
    n_rst = 1'b0;
    #1;
    chk("midrst_line_state", 32'(bus.line_state), 32'h2);
    chk("midrst_se0", 32'(bus.se0), 32'h0);
    chk("midrst_eop", 32'(bus.eop), 32'h0);
    chk("midrst_brst", 32'(bus.bus_reset), 32'h0);
    drive(SE0, 2);
    n_rst = 1'b1;
    drive(SE0, 4);
    drive(J, 6);
    chk("midrst_no_eop", 32'(eop_cnt), 32'd0);
    chk("midrst_no_err", 32'(err_cnt), 32'd0);

    clear_mon();
    for (int i = 0; i < 60; i++) begin
      int n;
      n = (i % 20 == 19) ? int'($urandom_range(195, 205)) : int'($urandom_range(1, 40));
      drive(SE0, n);
      case ($urandom_range(0, 3))
        0:       sym = K;
        1:       sym = SE1;
        default: sym = J;
      endcase
      drive(sym, 1);
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
        sym = 2'($urandom_range(1, 3));
        drive(sym, 1);
      end
    end
    drive(J, 4);
    chk("random_no_clash", 32'(clash_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_eop_linestate.md
Name: usb_eop_linestate

Overview:
- Sequential, parametrised successor to the combinational SE0 detector in the USB receive path.
- Synchronises raw d_plus/d_minus into the clk domain and classifies the line state each cycle.
- Measures SE0 duration and qualifies an end-of-packet: SE0 for at least MIN_EOP_CLKS cycles followed by J.
- Separately flags bus reset (long SE0) and malformed EOPs. Feeds the RX decoder/timer FSM.

Parameters:
- MIN_EOP_CLKS, 12, minimum consecutive synced SE0 cycles for a valid EOP (≥1).
- MAX_EOP_CLKS, 24, maximum SE0 cycles for a valid EOP; used only with the optional feature (> MIN_EOP_CLKS).
- RESET_CLKS, 200, SE0 cycles at which bus reset is declared (> MAX_EOP_CLKS).
- CNT_W, $clog2(RESET_CLKS+1), localparam, width of the SE0 counter.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- d_plus  in  1  raw USB D+ line, asynchronous.
- d_minus  in  1  raw USB D- line, asynchronous.
- line_state  out  2  synced line state {dp,dm}: SE0=00, K=01, J=10, SE1=11.
- se0  out  1  synced line is SE0 (combinational decode of synced pair).
- eop  out  1  one-cycle pulse on valid EOP.
- eop_err  out  1  one-cycle pulse on malformed EOP.
- bus_reset  out  1  level, high while bus reset is in progress.

Behaviour:
- Reset values: sync flops dp=1, dm=0 (J/idle), so line_state=10 and se0=0. eop=0, eop_err=0, bus_reset=0, cnt=0, FSM=IDLE.
- Synchroniser: two flops per line. line_state is the second stage, giving 2 edges of latency from a raw change.
- se0_cnt:
  - Loaded with 1 on the IDLE→SE0_RUN transition.
  - Incremented each cycle the synced line stays SE0 in SE0_RUN.
  - Saturates at RESET_CLKS and never wraps.
- FSM states: IDLE, SE0_RUN, BUS_RST.
- IDLE:
  - Synced SE0 → SE0_RUN, cnt=1.
  - Otherwise stay.
- SE0_RUN while synced SE0:
  - cnt++.
  - If the next cnt == RESET_CLKS → BUS_RST, and bus_reset rises on the same edge.
- SE0_RUN when synced line leaves SE0 (go to IDLE on the same edge in every case):
  - cnt < MIN_EOP_CLKS: glitch. No pulse.
  - cnt ≥ MIN_EOP_CLKS and line is J: eop=1 for exactly one cycle.
  - cnt ≥ MIN_EOP_CLKS and line is K or SE1: eop_err=1 for one cycle.
- BUS_RST:
  - bus_reset held high while synced SE0.
  - First non-SE0 cycle → IDLE, bus_reset low on that edge. No eop or eop_err.
- Outputs are registered. eop/eop_err assert on the edge that samples the first synced non-SE0 cycle, which is 3 edges after the raw J.
- eop and eop_err are never high in the same cycle. eop is never asserted while bus_reset is high.
- SE1 in IDLE: no action; it is reported only via line_state.
- Async reset mid-SE0 returns everything to reset values immediately. A following SE0 needs a fresh count; no pulse is emitted.

Optional Feature:
- Macro: USB_EOP_MAXLEN_EN.
- Defined: in SE0_RUN, an exit to J with MIN_EOP_CLKS ≤ cnt ≤ MAX_EOP_CLKS gives eop. An exit with MAX_EOP_CLKS < cnt < RESET_CLKS gives eop_err instead of eop.
- Undefined: no upper bound. Any cnt ≥ MIN_EOP_CLKS below RESET_CLKS exiting to J gives eop, and MAX_EOP_CLKS is unused.

Decomposition:
- Package usb_rx_pkg holds:
  - typedef enum logic [1:0] line_state_t {LS_SE0=2'b00, LS_K=2'b01, LS_J=2'b10, LS_SE1=2'b11}.
  - typedef enum eop_state_t {IDLE, SE0_RUN, BUS_RST}.
  - Default timing constants.
- One sub-module: usb_sync2. It is a two-flop synchroniser with parameter RST_VAL and async active-low reset, instantiated once per line.

Test Plan:
- Idle J, then raw SE0 for 12 cycles, then J → single eop pulse 3 edges after raw J. eop_err=0, bus_reset=0.
- Raw SE0 for 11 cycles, then J → no eop, no eop_err. FSM back in IDLE.
- SE0 for 16 cycles, then K → eop_err pulse for one cycle, no eop.
- SE0 for 250 cycles, then J:
  - bus_reset rises on the cycle cnt reaches 200.
  - bus_reset falls on the first synced J.
  - eop is never asserted.
- With USB_EOP_MAXLEN_EN:
  - SE0 for 30 cycles then J → eop_err.
  - SE0 for 20 cycles then J → eop.
  - Without the macro, SE0 for 30 cycles then J → eop.
- n_rst asserted at cycle 8 of a 12-cycle SE0, released, then 4 more SE0 cycles followed by J → no eop. Outputs read reset values during reset.
